glb_iact_read_arbiter: RTL and testbench

- Shares the single GLB iact read port between NUM_REQ router ports (west, north, east, south iact routers).
- Round-robin, burst-locked arbitration: the granted router owns the port for up to BURST_LEN consecutive reads.
- Forwards the winner's address and request to the GLB.
- Tracks in-flight reads with a tag pipeline and returns each GLB data word with a one-hot valid to the router that issued it.

---
 rtl/glb_iact_read_arbiter.sv | 150 +++++++++++++++
 tb/tb_glb_iact_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_iact_read_arbiter.sv
// Round-robin, burst-locked arbiter that shares the GLB iact read port among the
// iact routers and steers each returning data word back to the router that issued it.
module glb_iact_read_arbiter #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 4,
  parameter int BURST_LEN         = 4,
  parameter int READ_LATENCY      = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] addr_i,
  output logic [NUM_REQ-1:0]                   grant_o,
  output logic [ADDR_BITWIDTH_GLB-1:0]         glb_addr_o,
  output logic                                 glb_req_o,
  input  logic [DATA_BITWIDTH-1:0]             glb_data_i,
  output logic [DATA_BITWIDTH-1:0]             data_o,
  output logic [NUM_REQ-1:0]                   valid_o,
  output logic                                 busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state_r;
  logic                   rearb_r;
  logic [IDX_W-1:0]       owner_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_hold_r;
  logic [READ_LATENCY-1:0] pipe_vld_r;
  logic [IDX_W-1:0]       pipe_tag_r [READ_LATENCY];

  logic                   arb_s;
  logic                   any_req_s;
  logic [IDX_W-1:0]       winner_s;
  logic [IDX_W-1:0]       cur_owner_s;
  logic [CNT_W-1:0]       cur_cnt_s;
  logic                   issue_s;
  logic                   burst_end_s;
  logic [IDX_W-1:0]       next_ptr_s;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_sel_s;

  // Round-robin search: walk offsets downward so the smallest offset from rr_ptr wins.
  always_comb begin
    winner_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [IDX_W:0] cand;
      cand = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
      cand = (cand >= NUM_EXT) ? (cand - NUM_EXT) : cand;
      winner_s = req_i[cand[IDX_W-1:0]] ? cand[IDX_W-1:0] : winner_s;
    end
  end

  // Current issuer and burst bookkeeping; arb_s covers IDLE and the re-arbitration cycle.
  always_comb begin
    arb_s       = (state_r == IDLE) || rearb_r;
    any_req_s   = |req_i;
    cur_owner_s = arb_s ? winner_s : owner_r;
    cur_cnt_s   = arb_s ? '0 : cnt_r;
    issue_s     = reset && req_i[cur_owner_s];
    burst_end_s = (!arb_s && !req_i[owner_r]) || (issue_s && (cur_cnt_s == LAST_CNT));
    next_ptr_s  = (cur_owner_s == LAST_IDX) ? '0 : (cur_owner_s + IDX_W'(1));
    addr_sel_s  = addr_i[int'(cur_owner_s) * ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
  end

  // Port-facing issue and return outputs.
  always_comb begin
    grant_o    = '0;
    glb_addr_o = addr_hold_r;
    glb_req_o  = issue_s;
    if (issue_s) begin
      grant_o[cur_owner_s] = 1'b1;
      glb_addr_o           = addr_sel_s;
    end else begin
      grant_o    = '0;
      glb_addr_o = addr_hold_r;
    end
    valid_o = '0;
    if (pipe_vld_r[READ_LATENCY-1]) begin
      valid_o[pipe_tag_r[READ_LATENCY-1]] = 1'b1;
    end else begin
      valid_o = '0;
    end
    data_o = reset ? glb_data_i : '0;
    busy_o = (state_r == BURST) || (|pipe_vld_r);
  end

  // Burst ownership FSM: owner, round-robin pointer and read count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      rearb_r  <= 1'b0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (burst_end_s) begin
      rr_ptr_r <= next_ptr_s;
      cnt_r    <= '0;
      rearb_r  <= any_req_s;
      state_r  <= any_req_s ? BURST : IDLE;
    end else if (issue_s) begin
      state_r  <= BURST;
      rearb_r  <= 1'b0;
      owner_r  <= cur_owner_s;
      cnt_r    <= cur_cnt_s + CNT_W'(1);
    end else begin
      state_r  <= IDLE;
      rearb_r  <= 1'b0;
    end
  end

  // Return-tag pipeline; a bubble is shifted in on cycles without an issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_tag_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= issue_s;
      pipe_tag_r[0] <= cur_owner_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
    end
  end

  // Last issued address, held on the GLB port between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hold_r <= '0;
    end else if (issue_s) begin
      addr_hold_r <= addr_sel_s;
    end else begin
      addr_hold_r <= addr_hold_r;
    end
  end

endmodule

// File: tb/tb_glb_iact_read_arbiter.sv
// Bench for glb_iact_read_arbiter: two configurations driven by shared stimulus,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_glb_iact_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] addr_bus;
  logic [15:0] glb_data;

  logic [3:0]  grant_a, valid_a, grant_b, valid_b;
  logic [9:0]  gaddr_a, gaddr_b;
  logic        greq_a, greq_b, busy_a, busy_b;
  logic [15:0] data_a, data_b;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int         m_owner [2];
  int         m_ptr   [2];
  int         m_cnt   [2];
  bit         m_burst [2];
  logic [9:0] m_addr  [2];
  int         sched   [2][8];

  always #5 clk = ~clk;

  glb_iact_read_arbiter #(
    .DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10), .NUM_REQ(4), .BURST_LEN(4), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset(reset), .req_i(req), .addr_i(addr_bus), .grant_o(grant_a),
    .glb_addr_o(gaddr_a), .glb_req_o(greq_a), .glb_data_i(glb_data), .data_o(data_a),
    .valid_o(valid_a), .busy_o(busy_a)
  );

  glb_iact_read_arbiter #(
    .DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10), .NUM_REQ(4), .BURST_LEN(1), .READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(reset), .req_i(req), .addr_i(addr_bus), .grant_o(grant_b),
    .glb_addr_o(gaddr_b), .glb_req_o(greq_b), .glb_data_i(glb_data), .data_o(data_b),
    .valid_o(valid_b), .busy_o(busy_b)
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
  endtask

  function automatic int first_from(input int p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  task automatic model_clear(input int k);
    m_owner[k] = -1;
    m_ptr[k]   = 0;
    m_cnt[k]   = 0;
    m_burst[k] = 1'b0;
    m_addr[k]  = 10'd0;
    for (int j = 0; j < 8; j++) sched[k][j] = -1;
  endtask

  // One cycle of the reference: who issues now, what returns now, then advance.
  task automatic model_cycle(input int k);
    logic [3:0]  g, v, ev;
    logic [9:0]  a, ea;
    logic        r, b, bsy, iss, ended;
    logic [15:0] d;
    int o, cnt, lat, blen, slot;
    if (k == 0) begin
      g = grant_a; v = valid_a; a = gaddr_a; r = greq_a; b = busy_a; d = data_a;
    end else begin
      g = grant_b; v = valid_b; a = gaddr_b; r = greq_b; b = busy_b; d = data_b;
    end
    lat  = (k == 0) ? 1 : 3;
    blen = (k == 0) ? 4 : 1;
    slot = cyc % 8;
    if (!reset) begin
      chk("rst_grant", k, 32'(g), 32'd0);
      chk("rst_req",   k, 32'(r), 32'd0);
      chk("rst_addr",  k, 32'(a), 32'd0);
      chk("rst_valid", k, 32'(v), 32'd0);
      chk("rst_busy",  k, 32'(b), 32'd0);
      chk("rst_data",  k, 32'(d), 32'd0);
      model_clear(k);
    end else begin
      if (m_owner[k] < 0) begin
        o = first_from(m_ptr[k], req);
        cnt = 0;
      end else begin
        o = m_owner[k];
        cnt = m_cnt[k];
      end
      iss = req[o];
      ev  = (sched[k][slot] >= 0) ? 4'(1 << sched[k][slot]) : 4'd0;
      bsy = m_burst[k];
      for (int j = 0; j < lat; j++) begin
        if (sched[k][(cyc + j) % 8] >= 0) bsy = 1'b1;
      end
      ea = iss ? addr_bus[o*10 +: 10] : m_addr[k];
      chk("grant", k, 32'(g), iss ? 32'(1 << o) : 32'd0);
      chk("glb_req", k, 32'(r), 32'(iss));
      chk("glb_addr", k, 32'(a), 32'(ea));
      chk("valid", k, 32'(v), 32'(ev));
      chk("busy", k, 32'(b), 32'(bsy));
      chk("data", k, 32'(d), 32'(glb_data));
      sched[k][slot] = -1;
      if (iss) begin
        sched[k][(cyc + lat) % 8] = o;
        m_addr[k] = ea;
      end
      if (m_owner[k] < 0 && req == 4'd0) begin
        m_burst[k] = 1'b0;
      end else begin
        ended = !iss || (cnt == blen - 1);
        if (ended) begin
          m_ptr[k]   = (o + 1) % 4;
          m_owner[k] = -1;
          m_cnt[k]   = 0;
          m_burst[k] = (req != 4'd0);
        end else begin
          m_owner[k] = o;
          m_cnt[k]   = cnt + 1;
          m_burst[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    forever begin
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
      cyc++;
    end
  end

  task automatic drive(input logic [3:0] r);
    @(posedge clk);
    #1;
    req      = r;
    addr_bus = {$urandom, $urandom};
    glb_data = 16'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] prev;
    reset = 1'b0;
    req = 4'd0;
    addr_bus = 40'd0;
    glb_data = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // single requester, addresses 100..105
    for (int j = 0; j < 8; j++) begin
      drive((j < 6) ? 4'b0001 : 4'b0000);
      if (j < 6) addr_bus[9:0] = 10'(100 + j);
      @(negedge clk);
      if (j < 6) begin
        chk("p1_grant", 0, 32'(grant_a), 32'd1);
        chk("p1_addr", 0, 32'(gaddr_a), 32'(100 + j));
        chk("p1_grant", 1, 32'(grant_b), 32'd1);
      end
      if (j >= 1 && j <= 6) chk("p1_valid", 0, 32'(valid_a), 32'd1);
      if (j >= 3) chk("p1_valid", 1, 32'(valid_b), 32'd1);
      if (j == 6) chk("p1_busy_hi", 0, 32'(busy_a), 32'd1);
      if (j == 7) chk("p1_busy_lo", 0, 32'(busy_a), 32'd0);
    end

    // all requesting: bursts of 4 (dut0) and of 1 (dut1) rotating without gaps
    do_reset();
    for (int j = 0; j < 16; j++) begin
      drive(4'b1111);
      @(negedge clk);
      chk("p2_rr", 0, 32'(grant_a), 32'(1 << (j / 4)));
      chk("p2_rr", 1, 32'(grant_b), 32'(1 << (j % 4)));
    end

    // router 2 drops after two reads, router 3 follows
    do_reset();
    for (int j = 0; j < 4; j++) begin
      drive((j < 2) ? 4'b1100 : 4'b1000);
      @(negedge clk);
      chk("p3_grant", 0, 32'(grant_a), (j < 2) ? 32'h4 : ((j == 2) ? 32'h0 : 32'h8));
    end

    // rr_ptr=3 after router 2's full burst, then 0101 wraps to router 0 first
    do_reset();
    for (int j = 0; j < 9; j++) begin
      drive((j < 4) ? 4'b0100 : 4'b0101);
      @(negedge clk);
      chk("p4_grant", 0, 32'(grant_a), (j < 4 || j == 8) ? 32'h4 : 32'h1);
    end

    // latency-3 tagging with single-read bursts alternating routers 1 and 3
    do_reset();
    for (int j = 0; j < 11; j++) begin
      drive(4'b1010);
      @(negedge clk);
      chk("p5_grant", 1, 32'(grant_b), (j % 2 == 0) ? 32'h2 : 32'h8);
      if (j < 3) chk("p5_valid", 1, 32'(valid_b), 32'd0);
      else chk("p5_valid", 1, 32'(valid_b), ((j - 3) % 2 == 0) ? 32'h2 : 32'h8);
    end

    // asynchronous reset with reads in flight
    do_reset();
    for (int j = 0; j < 3; j++) drive(4'b0011);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("p6_grant", 0, 32'(grant_a), 32'd0);
    chk("p6_req", 0, 32'(greq_a), 32'd0);
    chk("p6_busy", 0, 32'(busy_a), 32'd0);
    chk("p6_valid", 1, 32'(valid_b), 32'd0);
    chk("p6_busy", 1, 32'(busy_b), 32'd0);
    chk("p6_addr", 1, 32'(gaddr_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("p6_first", 0, 32'(grant_a), 32'h2);
    chk("p6_first", 1, 32'(grant_b), 32'h2);
    chk("p6_novalid", 0, 32'(valid_a), 32'd0);
    for (int j = 0; j < 3; j++) begin
      chk("p6_novalid", 1, 32'(valid_b), 32'd0);
      drive(4'b0110);
      @(negedge clk);
    end

    // randomized traffic with occasional asynchronous resets
    prev = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        if ($urandom_range(0, 3) == 0) prev = 4'($urandom_range(0, 15));
        drive(prev);
      end
    end

    drive(4'b0000);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
